reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//   Shares the register file's single write port between NUM_REQ writeback sources (ALU, load unit, mul/div).
//   - Round-robin arbitration with a valid/ready handshake per requester.
//   - One registered output stage drives the write port.
//   - x0 writes are discarded.
//   - pend_mask publishes the register currently in flight, for decode hazard checks.
// PARAMETERS
//   NUM_REQ  3   number of writeback requesters (2..8)
//   AW       5   register address width (32 registers)
//   DW       32  write data width
// PORTS
//   clk        in   1           clock; all state changes on posedge
//   rst_n      in   1           asynchronous active-low reset
//   req_valid  in   NUM_REQ     requester i presents a write
//   req_ready  out  NUM_REQ     requester i's write accepted this cycle
//   req_waddr  in   NUM_REQ*AW  packed destination addresses; slice i = [i*AW +: AW]
//   req_wdata  in   NUM_REQ*DW  packed write data; slice i = [i*DW +: DW]
//   rf_stall   in   1           register file cannot take a write this cycle
//   rf_waddr   out  AW          to the register file write address
//   rf_wdata   out  DW          to the register file write data
//   rf_wren    out  1           to the register file write enable
//   pend_mask  out  2**AW       one-hot of the address held in the output stage; 0 if empty
// BEHAVIOUR
//   Reset:
//   - out_vld=0, rf_waddr=0, rf_wdata=0, rf_wren=0, pend_mask=0, rr_ptr=0.
//   - Takes effect immediately on rst_n fall; an in-flight write is dropped.
//   Arbitration (combinational):
//   - Scan requesters starting at rr_ptr, in increasing index with wrap.
//   - The first with req_valid=1 gets grant (one-hot, or 0 if none valid).
//   Handshake:
//   - load     = ~out_vld | ~rf_stall.
//   - req_ready = grant & {NUM_REQ{load}}.
//   - A transfer occurs when req_valid[i] & req_ready[i].
//   - Requesters must hold waddr/wdata stable while valid=1 and ready=0.
//   Output stage, on posedge:
//   - If load: out_vld <= |grant.
//     On a transfer: out_waddr/out_wdata <= granted slice; rr_ptr <= (g+1) mod NUM_REQ, where g is the granted index.
//   - Else (stalled): hold all state; rr_ptr does not move.
//   - rr_ptr advances only on a transfer.
//   Outputs:
//   - rf_wren = out_vld & ~rf_stall & (out_waddr != 0).
//   - rf_waddr = out_waddr; rf_wdata = out_wdata (held across stall).
//   - Latency: transfer in cycle N -> rf_wren in cycle N+1 if not stalled.
//   - Throughput: 1 write/cycle.
//   x0:
//   - A transfer to address 0 is accepted normally (ready=1, pointer advances).
//   - rf_wren stays 0 for it and pend_mask stays 0.
//   pend_mask:
//   - Bit out_waddr set while out_vld=1 and out_waddr!=0; all zero otherwise.
//   Boundaries:
//   - All requesters valid: grants rotate rr_ptr, rr_ptr+1, ... with no starvation; max wait NUM_REQ-1 transfers.
//   - rf_stall while empty: a request is still accepted (load=1) and is then held.
//   - rf_stall while full: all req_ready=0.
//   - Same address back-to-back from different requesters: written in grant order; the later write wins.
//   - rr_ptr wraps from NUM_REQ-1 to 0.
// CONFIGURATION
//   REG_WB_TRACE_EN defined:
//   - On each cycle with rf_wren=1, $display("WB[%0d] REG[%0d]=%0d", g_out, rf_waddr, rf_wdata).
//   - g_out is the requester index, stored alongside the output stage.
//   Not defined:
//   - No display and no g_out storage.
//   - Port-level behaviour is identical either way.
// STRUCTURE
//   reg_pkg:
//   - constants REG_AW=5, REG_DW=32, REG_NUM=32.
//   - typedef rf_wr_t {addr, data}.
//   rr_arbiter sub-module:
//   - NUM_REQ-wide rotating-priority arbiter: inputs req, ptr; output grant one-hot plus encoded index.
//   - Reused later for the read-port arbiter.
//   Top level: handshake logic, output stage, pend_mask decode, trace.
// TESTING
//   1. Req0 alone, waddr=5, wdata=0xDEAD, rf_stall=0 -> ready0=1 in cycle N; rf_wren=1, rf_waddr=5, rf_wdata=0xDEAD in N+1; pend_mask=1<<5 in N+1.
//   2. Req0..2 all valid for 6 cycles from reset -> grant order 0,1,2,0,1,2; one rf_wren per cycle.
//   3. Holding write to reg 7, rf_stall=1 for 3 cycles, req1 valid -> req_ready=0 and outputs held for 3 cycles; 7 written when stall drops; req1 accepted that same cycle.
//   4. Req2 writes addr 0, data 0x1234 -> ready2=1, rr_ptr->0, rf_wren stays 0, pend_mask=0.
//   5. rst_n low mid-stream with a write to reg 9 held -> rf_wren=0 and pend_mask=0 immediately; after release the first grant goes to req0.
//   6. Req0 then req1 write reg 3 (0x11, then 0x22) -> two rf_wren cycles in that order; final value 0x22.

Source files
------------

// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - register file shared constants and write record type
package reg_pkg;
  localparam int REG_AW  = 5;
  localparam int REG_DW  = 32;
  localparam int REG_NUM = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority arbiter, scan starts at ptr and wraps
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin : scan
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - round-robin writeback arbiter for the register file write port
// Optional REG_WB_TRACE_EN: keeps the granted index with the output stage and prints each write.
module reg_wb_arbiter
  import reg_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = REG_AW,
  parameter int DW      = REG_DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*AW-1:0] req_waddr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  input  logic                  rf_stall,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic                  rf_wren,
  output logic [(1<<AW)-1:0]    pend_mask
);

  localparam int IW = $clog2(NUM_REQ);

  logic [AW-1:0] waddr_a [NUM_REQ];
  logic [DW-1:0] wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign waddr_a[i] = req_waddr[i*AW +: AW];
    assign wdata_a[i] = req_wdata[i*DW +: DW];
  end

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic               load;
  logic               xfer;

  logic          out_vld_q,   out_vld_d;
  logic [AW-1:0] out_waddr_q, out_waddr_d;
  logic [DW-1:0] out_wdata_q, out_wdata_d;
  logic [IW-1:0] rr_ptr_q,    rr_ptr_d;
`ifdef REG_WB_TRACE_EN
  logic [IW-1:0] g_out_q,     g_out_d;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // A full stage blocks new grants only while the register file is stalling it.
  always_comb begin
    load        = ~out_vld_q | ~rf_stall;
    xfer        = load & (|grant);
    req_ready   = grant & {NUM_REQ{load}};
    out_vld_d   = out_vld_q;
    out_waddr_d = out_waddr_q;
    out_wdata_d = out_wdata_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef REG_WB_TRACE_EN
    g_out_d     = g_out_q;
`endif
    if (load) out_vld_d = |grant;
    if (xfer) begin
      out_waddr_d = waddr_a[gidx];
      out_wdata_d = wdata_a[gidx];
      rr_ptr_d    = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
`ifdef REG_WB_TRACE_EN
      g_out_d     = gidx;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q   <= 1'b0;
      out_waddr_q <= '0;
      out_wdata_q <= '0;
      rr_ptr_q    <= '0;
`ifdef REG_WB_TRACE_EN
      g_out_q     <= '0;
`endif
    end else begin
      out_vld_q   <= out_vld_d;
      out_waddr_q <= out_waddr_d;
      out_wdata_q <= out_wdata_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef REG_WB_TRACE_EN
      g_out_q     <= g_out_d;
`endif
    end
  end

  assign rf_waddr = out_waddr_q;
  assign rf_wdata = out_wdata_q;
  assign rf_wren  = out_vld_q & ~rf_stall & (out_waddr_q != '0);

  // x0 never shows as pending since its write is discarded.
  always_comb begin
    pend_mask = '0;
    if (out_vld_q && out_waddr_q != '0) pend_mask[out_waddr_q] = 1'b1;
  end

`ifdef REG_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (rf_wren) $display("WB[%0d] REG[%0d]=%0d", g_out_q, rf_waddr, rf_wdata);
  end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_waddr;
  logic [95:0] req_wdata;
  logic        rf_stall;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wren;
  logic [31:0] pend_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .rf_stall  (rf_stall),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_wren   (rf_wren),
    .pend_mask (pend_mask)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one pending write slot plus a "next to favour" pointer.
  logic        m_full;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_ptr;
  int          m_win;
  logic        m_load;

  function automatic int winner(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  always_comb begin
    m_win  = winner(req_valid, m_ptr);
    m_load = !m_full || !rf_stall;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_ptr  <= 0;
    end else if (m_load) begin
      m_full <= (m_win >= 0);
      if (m_win >= 0) begin
        m_addr <= req_waddr[m_win*5 +: 5];
        m_data <= req_wdata[m_win*32 +: 32];
        m_ptr  <= (m_win + 1) % 3;
      end
    end
  end

  logic [31:0] shadow_rf [32];
  always @(posedge clk) begin
    if (rf_wren) shadow_rf[rf_waddr] <= rf_wdata;
  end

  always @(negedge clk) begin
    logic [2:0]  e_ready;
    logic [31:0] e_pend;
    e_ready = (m_load && m_win >= 0) ? (3'b001 << m_win) : 3'b000;
    e_pend  = (m_full && m_addr != 0) ? (32'd1 << m_addr) : 32'd0;
    chk("model_ready", 64'(req_ready), 64'(e_ready));
    chk("model_wren",  64'(rf_wren),   64'(m_full && !rf_stall && m_addr != 0));
    chk("model_waddr", 64'(rf_waddr),  64'(m_addr));
    chk("model_wdata", 64'(rf_wdata),  64'(m_data));
    chk("model_pend",  64'(pend_mask), 64'(e_pend));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]          = v;
    req_waddr[i*5 +: 5]   = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;
    rf_stall  = 1'b0;
    for (int r = 0; r < 32; r++) shadow_rf[r] = '0;

    at_neg();
    chk("rst_wren", 64'(rf_wren), 64'd0);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    step();
    rst_n = 1'b1;

    // single write from req0
    set_req(0, 1'b1, 5'd5, 32'hDEAD);
    at_neg();
    chk("t1_ready", 64'(req_ready), 64'h1);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    at_neg();
    chk("t1_wren", 64'(rf_wren), 64'h1);
    chk("t1_waddr", 64'(rf_waddr), 64'h5);
    chk("t1_wdata", 64'(rf_wdata), 64'hDEAD);
    chk("t1_pend", 64'(pend_mask), 64'h20);
    step();

    // all valid from reset: rotation 0,1,2,0,1,2
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(10 + i), 32'(100 + i));
    for (int k = 0; k < 6; k++) begin
      logic [2:0] exp_g;
      exp_g = 3'b001 << (k % 3);
      at_neg();
      chk("t2_grant", 64'(req_ready), 64'(exp_g));
      if (k > 0) chk("t2_wren", 64'(rf_wren), 64'h1);
      step();
    end
    req_valid = '0;
    at_neg();
    chk("t2_last_wren", 64'(rf_wren), 64'h1);
    chk("t2_last_addr", 64'(rf_waddr), 64'd12);
    step();

    // stall while holding reg 7
    set_req(0, 1'b1, 5'd7, 32'h77);
    at_neg();
    chk("t3_load", 64'(req_ready), 64'h1);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd8, 32'h88);
    rf_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("t3_stall_ready", 64'(req_ready), 64'h0);
      chk("t3_stall_wren", 64'(rf_wren), 64'h0);
      chk("t3_stall_addr", 64'(rf_waddr), 64'h7);
      chk("t3_stall_pend", 64'(pend_mask), 64'h80);
      step();
    end
    rf_stall = 1'b0;
    at_neg();
    chk("t3_rel_wren", 64'(rf_wren), 64'h1);
    chk("t3_rel_addr", 64'(rf_waddr), 64'h7);
    chk("t3_rel_ready", 64'(req_ready), 64'h2);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    at_neg();
    chk("t3_r1_addr", 64'(rf_waddr), 64'h8);
    chk("t3_r1_data", 64'(rf_wdata), 64'h88);
    step();

    // x0 write from req2
    set_req(2, 1'b1, 5'd0, 32'h1234);
    at_neg();
    chk("t4_ready", 64'(req_ready), 64'h4);
    step();
    set_req(2, 1'b0, 5'd0, 32'h0);
    at_neg();
    chk("t4_wren", 64'(rf_wren), 64'h0);
    chk("t4_pend", 64'(pend_mask), 64'h0);
    step();

    // pointer wrapped to 0; then reset with reg 9 held
    set_req(0, 1'b1, 5'd9, 32'h99);
    set_req(1, 1'b1, 5'd4, 32'h44);
    at_neg();
    chk("t4_ptr_wrap", 64'(req_ready), 64'h1);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    rf_stall = 1'b1;
    at_neg();
    chk("t5_held_pend", 64'(pend_mask), 64'h200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wren", 64'(rf_wren), 64'h0);
    chk("t5_rst_pend", 64'(pend_mask), 64'h0);
    step();
    rst_n    = 1'b1;
    rf_stall = 1'b0;
    set_req(0, 1'b1, 5'd9, 32'h99);
    at_neg();
    chk("t5_first_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    at_neg();
    step();

    // same register back-to-back from req0 then req1
    set_req(0, 1'b1, 5'd3, 32'h11);
    at_neg();
    chk("t6_ready0", 64'(req_ready), 64'h1);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd3, 32'h22);
    at_neg();
    chk("t6_ready1", 64'(req_ready), 64'h2);
    chk("t6_first_data", 64'(rf_wdata), 64'h11);
    chk("t6_first_wren", 64'(rf_wren), 64'h1);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    at_neg();
    chk("t6_second_data", 64'(rf_wdata), 64'h22);
    chk("t6_second_wren", 64'(rf_wren), 64'h1);
    step();
    at_neg();
    chk("t6_final_reg3", 64'(shadow_rf[3]), 64'h22);
    chk("x0_never_written", 64'(shadow_rf[0]), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
